geom_kernel_unit: RTL and testbench

Fixed-point geometry kernel for the angle-force pipeline. It bundles three independent engines that share one clock and reset:
- a combinational 3-D cross product;
- a sequential vector normalizer that also returns the inverse magnitude;
- a sequential arccosine.

All data is signed Q16.16 (1.0 = 0x00010000). The angle-force controller drives each engine through its own start/busy/valid handshake.

---
 rtl/geom_kernel_unit.sv | 277 +++++++++++++++++++++++++++
 tb/tb_geom_kernel_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/geom_kernel_unit.sv
`default_nettype none
// ============================================================================
// Module   : geom_kernel_unit
// Purpose  : Q16.16 geometry kernel: combinational cross product, sequential
//            normalizer (unit vector + 1/|v|) and sequential arccosine.
//            Optional macro NORM_ZERO_FLAG_EN adds the norm_zero output.
// Revision : 1.0 - initial release
// ============================================================================
module geom_kernel_unit #(
    parameter int ACOS_TOL = 8,
    parameter int NORM_TOL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cp_ax,
    input  logic [31:0] cp_ay,
    input  logic [31:0] cp_az,
    input  logic [31:0] cp_bx,
    input  logic [31:0] cp_by,
    input  logic [31:0] cp_bz,
    output logic [31:0] cp_rx,
    output logic [31:0] cp_ry,
    output logic [31:0] cp_rz,
    input  logic        norm_start,
    input  logic [31:0] norm_vx,
    input  logic [31:0] norm_vy,
    input  logic [31:0] norm_vz,
    output logic [31:0] norm_nx,
    output logic [31:0] norm_ny,
    output logic [31:0] norm_nz,
    output logic [31:0] norm_inv_mag,
    output logic        norm_valid,
    output logic        norm_busy,
    input  logic        acos_start,
    input  logic [31:0] acos_x,
    output logic [31:0] acos_theta,
    output logic        acos_valid,
    output logic        acos_busy
`ifdef NORM_ZERO_FLAG_EN
    ,
    output logic        norm_zero
`endif
);

    localparam logic signed [31:0] c_clamp_hi = 32'sh3FFF_FFFF;
    localparam logic signed [31:0] c_one      = 32'sh0001_0000;
    localparam logic signed [31:0] c_pi       = 32'sd205887;
    localparam logic signed [31:0] c_a0       = 32'sd102939;
    localparam logic signed [31:0] c_a1       = -32'sd13901;
    localparam logic signed [31:0] c_a2       = 32'sd4867;
    localparam logic signed [31:0] c_a3       = -32'sd1227;

    // Tolerances only bound the checking side; this keeps them referenced.
    generate
        if ((ACOS_TOL < 0) || (NORM_TOL < 0)) begin : g_tol_check
        end
    endgenerate

    typedef enum logic [2:0] {
        N_IDLE = 3'd0, N_SQ = 3'd1, N_SQRT = 3'd2, N_DIV = 3'd3, N_SCALE = 3'd4, N_DONE = 3'd5
    } norm_state_t;

    typedef enum logic [2:0] {
        A_IDLE = 3'd0, A_CLAMP = 3'd1, A_SQRT = 3'd2, A_POLY = 3'd3, A_FIX = 3'd4, A_DONE = 3'd5
    } acos_state_t;

    function automatic logic signed [31:0] qmult(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return 32'(p >>> 16);
    endfunction

    function automatic logic signed [31:0] clamp30(input logic signed [31:0] v);
        if (v > c_clamp_hi)       return c_clamp_hi;
        else if (v < -c_clamp_hi) return -c_clamp_hi;
        else                      return v;
    endfunction

    function automatic logic [63:0] square(input logic signed [31:0] v);
        logic signed [63:0] w;
        w = 64'(v);
        return $unsigned(w * w);
    endfunction

    // One radicand bit-pair of a restoring square root: returns {rem, root}.
    function automatic logic [67:0] sqrt_step(input logic [35:0] rem, input logic [31:0] root,
                                              input logic [1:0] pair);
        logic [35:0] cur;
        logic [35:0] trial;
        cur   = 36'({rem, pair});
        trial = {2'b00, root, 2'b01};
        if (cur >= trial) return {cur - trial, 32'({root, 1'b1})};
        else              return {cur, 32'({root, 1'b0})};
    endfunction

    assign cp_rx = qmult(cp_ay, cp_bz) - qmult(cp_az, cp_by);
    assign cp_ry = qmult(cp_az, cp_bx) - qmult(cp_ax, cp_bz);
    assign cp_rz = qmult(cp_ax, cp_by) - qmult(cp_ay, cp_bx);

    norm_state_t        r_nstate_q, w_nstate_d;
    logic signed [31:0] r_vx_q, r_vy_q, r_vz_q, w_vx_d, w_vy_d, w_vz_d;
    logic [63:0]        r_nrad_q, w_nrad_d;
    logic [35:0]        r_nrem_q, w_nrem_d;
    logic [31:0]        r_nroot_q, w_nroot_d;
    logic [5:0]         r_ncnt_q, w_ncnt_d;
    logic [32:0]        r_dnum_q, w_dnum_d;
    logic [33:0]        r_drem_q, w_drem_d;
    logic [32:0]        r_quo_q, w_quo_d;
    logic [31:0]        r_nx_q, r_ny_q, r_nz_q, r_inv_q, w_nx_d, w_ny_d, w_nz_d, w_inv_d;
    logic               r_zero_q, w_zero_d;

    always_comb begin
        logic [33:0] rem_s;
        logic [31:0] inv;
        w_nstate_d = r_nstate_q;
        w_vx_d = r_vx_q;    w_vy_d = r_vy_q;    w_vz_d = r_vz_q;
        w_nrad_d = r_nrad_q; w_nrem_d = r_nrem_q; w_nroot_d = r_nroot_q;
        w_ncnt_d = r_ncnt_q; w_dnum_d = r_dnum_q; w_drem_d = r_drem_q; w_quo_d = r_quo_q;
        w_nx_d = r_nx_q;    w_ny_d = r_ny_q;    w_nz_d = r_nz_q;
        w_inv_d = r_inv_q;  w_zero_d = r_zero_q;
        rem_s = 34'({r_drem_q, r_dnum_q[32]});
        inv   = 32'd0;
        case (r_nstate_q)
            N_IDLE: if (norm_start) begin
                w_vx_d = norm_vx; w_vy_d = norm_vy; w_vz_d = norm_vz;
                w_nstate_d = N_SQ;
            end
            N_SQ: begin
                w_nrad_d  = square(clamp30(r_vx_q)) + square(clamp30(r_vy_q)) + square(clamp30(r_vz_q));
                w_nrem_d  = 36'd0;
                w_nroot_d = 32'd0;
                w_ncnt_d  = 6'd0;
                w_nstate_d = N_SQRT;
            end
            N_SQRT: begin
                {w_nrem_d, w_nroot_d} = sqrt_step(r_nrem_q, r_nroot_q, r_nrad_q[63:62]);
                w_nrad_d = {r_nrad_q[61:0], 2'b00};
                w_ncnt_d = r_ncnt_q + 6'd1;
                if (r_ncnt_q == 6'd31) begin
                    w_ncnt_d = 6'd0;
                    w_dnum_d = 33'h1_0000_0000;
                    w_drem_d = 34'd0;
                    w_quo_d  = 33'd0;
                    w_nstate_d = N_DIV;
                end
            end
            N_DIV: begin
                w_dnum_d = {r_dnum_q[31:0], 1'b0};
                if (rem_s >= {2'b00, r_nroot_q}) begin
                    w_drem_d = rem_s - {2'b00, r_nroot_q};
                    w_quo_d  = {r_quo_q[31:0], 1'b1};
                end else begin
                    w_drem_d = rem_s;
                    w_quo_d  = {r_quo_q[31:0], 1'b0};
                end
                w_ncnt_d = r_ncnt_q + 6'd1;
                if (r_ncnt_q == 6'd32) w_nstate_d = N_SCALE;
            end
            N_SCALE: begin
                // Zero magnitude divides to all-ones; force the defined zero result.
                if (r_nroot_q == 32'd0)         inv = 32'd0;
                else if (r_quo_q[32:31] != 2'd0) inv = 32'h7FFF_FFFF;
                else                             inv = r_quo_q[31:0];
                w_inv_d  = inv;
                w_nx_d   = qmult(r_vx_q, inv);
                w_ny_d   = qmult(r_vy_q, inv);
                w_nz_d   = qmult(r_vz_q, inv);
                w_zero_d = (r_nroot_q == 32'd0);
                w_nstate_d = N_DONE;
            end
            N_DONE:  w_nstate_d = N_IDLE;
            default: w_nstate_d = N_IDLE;
        endcase
    end

    acos_state_t        r_astate_q, w_astate_d;
    logic signed [31:0] r_ax_q, w_ax_d, r_u_q, w_u_d, r_p_q, w_p_d;
    logic               r_neg_q, w_neg_d;
    logic [63:0]        r_arad_q, w_arad_d;
    logic [35:0]        r_arem_q, w_arem_d;
    logic [31:0]        r_aroot_q, w_aroot_d;
    logic [4:0]         r_acnt_q, w_acnt_d;
    logic [31:0]        r_theta_q, w_theta_d;

    always_comb begin
        logic signed [31:0] xc, u, w, coef, t;
        w_astate_d = r_astate_q;
        w_ax_d = r_ax_q;     w_u_d = r_u_q;       w_p_d = r_p_q;     w_neg_d = r_neg_q;
        w_arad_d = r_arad_q; w_arem_d = r_arem_q; w_aroot_d = r_aroot_q;
        w_acnt_d = r_acnt_q; w_theta_d = r_theta_q;
        xc = (r_ax_q > c_one) ? c_one : ((r_ax_q < -c_one) ? -c_one : r_ax_q);
        u  = (xc < 0) ? -xc : xc;
        w  = c_one - u;
        coef = (r_acnt_q == 5'd0) ? c_a2 : ((r_acnt_q == 5'd1) ? c_a1 : c_a0);
        t  = qmult($signed(r_aroot_q), r_p_q);
        case (r_astate_q)
            A_IDLE: if (acos_start) begin
                w_ax_d = acos_x;
                w_astate_d = A_CLAMP;
            end
            A_CLAMP: begin
                w_neg_d   = (xc < 0);
                w_u_d     = u;
                w_arad_d  = 64'({w, 16'h0000});
                w_arem_d  = 36'd0;
                w_aroot_d = 32'd0;
                w_acnt_d  = 5'd0;
                w_astate_d = A_SQRT;
            end
            A_SQRT: begin
                {w_arem_d, w_aroot_d} = sqrt_step(r_arem_q, r_aroot_q, r_arad_q[63:62]);
                w_arad_d = {r_arad_q[61:0], 2'b00};
                w_acnt_d = r_acnt_q + 5'd1;
                if (r_acnt_q == 5'd31) begin
                    w_acnt_d = 5'd0;
                    w_p_d    = c_a3;
                    w_astate_d = A_POLY;
                end
            end
            A_POLY: begin
                // Horner steps a2, a1, a0 reuse one multiplier.
                w_p_d    = coef + qmult(r_u_q, r_p_q);
                w_acnt_d = r_acnt_q + 5'd1;
                if (r_acnt_q == 5'd2) w_astate_d = A_FIX;
            end
            A_FIX: begin
                w_theta_d  = r_neg_q ? (c_pi - t) : t;
                w_astate_d = A_DONE;
            end
            A_DONE:  w_astate_d = A_IDLE;
            default: w_astate_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nstate_q <= N_IDLE;
            r_vx_q <= '0;   r_vy_q <= '0;   r_vz_q <= '0;
            r_nrad_q <= '0; r_nrem_q <= '0; r_nroot_q <= '0; r_ncnt_q <= '0;
            r_dnum_q <= '0; r_drem_q <= '0; r_quo_q <= '0;
            r_nx_q <= '0;   r_ny_q <= '0;   r_nz_q <= '0;    r_inv_q <= '0; r_zero_q <= 1'b0;
            r_astate_q <= A_IDLE;
            r_ax_q <= '0;   r_u_q <= '0;    r_p_q <= '0;     r_neg_q <= 1'b0;
            r_arad_q <= '0; r_arem_q <= '0; r_aroot_q <= '0; r_acnt_q <= '0; r_theta_q <= '0;
        end else begin
            r_nstate_q <= w_nstate_d;
            r_vx_q <= w_vx_d;     r_vy_q <= w_vy_d;     r_vz_q <= w_vz_d;
            r_nrad_q <= w_nrad_d; r_nrem_q <= w_nrem_d; r_nroot_q <= w_nroot_d; r_ncnt_q <= w_ncnt_d;
            r_dnum_q <= w_dnum_d; r_drem_q <= w_drem_d; r_quo_q <= w_quo_d;
            r_nx_q <= w_nx_d;     r_ny_q <= w_ny_d;     r_nz_q <= w_nz_d;
            r_inv_q <= w_inv_d;   r_zero_q <= w_zero_d;
            r_astate_q <= w_astate_d;
            r_ax_q <= w_ax_d;     r_u_q <= w_u_d;       r_p_q <= w_p_d;         r_neg_q <= w_neg_d;
            r_arad_q <= w_arad_d; r_arem_q <= w_arem_d; r_aroot_q <= w_aroot_d; r_acnt_q <= w_acnt_d;
            r_theta_q <= w_theta_d;
        end
    end

    assign norm_nx      = r_nx_q;
    assign norm_ny      = r_ny_q;
    assign norm_nz      = r_nz_q;
    assign norm_inv_mag = r_inv_q;
    assign norm_valid   = (r_nstate_q == N_DONE);
    assign norm_busy    = (r_nstate_q != N_IDLE) && (r_nstate_q != N_DONE);
    assign acos_theta   = r_theta_q;
    assign acos_valid   = (r_astate_q == A_DONE);
    assign acos_busy    = (r_astate_q != A_IDLE) && (r_astate_q != A_DONE);

`ifdef NORM_ZERO_FLAG_EN
    assign norm_zero = r_zero_q;
`else
    logic w_zero_unused;
    assign w_zero_unused = r_zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_geom_kernel_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_geom_kernel_unit
// Purpose  : Directed self-checking bench for geom_kernel_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_geom_kernel_unit;

    localparam int c_norm_tol = 2;
    localparam int c_acos_tol = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cp_ax = '0, cp_ay = '0, cp_az = '0, cp_bx = '0, cp_by = '0, cp_bz = '0;
    logic [31:0] cp_rx, cp_ry, cp_rz;
    logic        norm_start = 1'b0;
    logic [31:0] norm_vx = '0, norm_vy = '0, norm_vz = '0;
    logic [31:0] norm_nx, norm_ny, norm_nz, norm_inv_mag;
    logic        norm_valid, norm_busy;
    logic        acos_start = 1'b0;
    logic [31:0] acos_x = '0;
    logic [31:0] acos_theta;
    logic        acos_valid, acos_busy;
`ifdef NORM_ZERO_FLAG_EN
    logic        norm_zero;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    geom_kernel_unit #(.ACOS_TOL(c_acos_tol), .NORM_TOL(c_norm_tol)) dut (
        .clk(clk), .rst_n(rst_n),
        .cp_ax(cp_ax), .cp_ay(cp_ay), .cp_az(cp_az),
        .cp_bx(cp_bx), .cp_by(cp_by), .cp_bz(cp_bz),
        .cp_rx(cp_rx), .cp_ry(cp_ry), .cp_rz(cp_rz),
        .norm_start(norm_start), .norm_vx(norm_vx), .norm_vy(norm_vy), .norm_vz(norm_vz),
        .norm_nx(norm_nx), .norm_ny(norm_ny), .norm_nz(norm_nz), .norm_inv_mag(norm_inv_mag),
        .norm_valid(norm_valid), .norm_busy(norm_busy),
        .acos_start(acos_start), .acos_x(acos_x), .acos_theta(acos_theta),
        .acos_valid(acos_valid), .acos_busy(acos_busy)
`ifdef NORM_ZERO_FLAG_EN
        , .norm_zero(norm_zero)
`endif
    );

    function automatic int absdiff(input logic [31:0] a, input int b);
        int d;
        d = $signed(a) - b;
        return (d < 0) ? -d : d;
    endfunction

    // Issues one normalize request (start held until busy) and watches 100 cycles.
    task automatic norm_request(input logic [31:0] vx, input logic [31:0] vy, input logic [31:0] vz,
                                output int lat, output int nvalid, output logic busy_at_valid);
        int guard;
        @(negedge clk);
        norm_vx = vx; norm_vy = vy; norm_vz = vz; norm_start = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!norm_busy && guard < 10);
        norm_start = 1'b0;
        lat = -1; nvalid = 0; busy_at_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (norm_valid) begin
                nvalid++;
                if (nvalid == 1) begin lat = i; busy_at_valid = norm_busy; end
            end
            @(negedge clk);
        end
    endtask

    task automatic acos_request(input logic [31:0] x, output int lat, output int nvalid);
        int guard;
        @(negedge clk);
        acos_x = x; acos_start = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!acos_busy && guard < 10);
        acos_start = 1'b0;
        lat = -1; nvalid = 0;
        for (int i = 0; i < 60; i++) begin
            if (acos_valid) begin
                nvalid++;
                if (nvalid == 1) lat = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({norm_valid, norm_busy, acos_valid, acos_busy} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got=%b want=0000", {norm_valid, norm_busy, acos_valid, acos_busy});
        end
        n_total++;
        if ({norm_nx, norm_ny, norm_nz, norm_inv_mag, acos_theta} !== 160'd0) begin
            n_bad++; $display("FAIL reset_data got nx=%h inv=%h theta=%h want 0", norm_nx, norm_inv_mag, acos_theta);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cross();
        logic [31:0] va [3][6];
        logic [31:0] exp_r [3][3];
        va[0] = '{32'h10000, 32'h0, 32'h0, 32'h0, 32'h10000, 32'h0};
        exp_r[0] = '{32'h0, 32'h0, 32'h10000};
        va[1] = '{32'h20000, 32'h30000, 32'h10000, 32'h20000, 32'h30000, 32'h10000};
        exp_r[1] = '{32'h0, 32'h0, 32'h0};
        va[2] = '{32'h10000, 32'h20000, 32'h30000, 32'h40000, 32'h50000, 32'h60000};
        exp_r[2] = '{32'hFFFD0000, 32'h00060000, 32'hFFFD0000};
        for (int k = 0; k < 3; k++) begin
            {cp_ax, cp_ay, cp_az} = {va[k][0], va[k][1], va[k][2]};
            {cp_bx, cp_by, cp_bz} = {va[k][3], va[k][4], va[k][5]};
            #1;
            n_total++;
            if ({cp_rx, cp_ry, cp_rz} !== {exp_r[k][0], exp_r[k][1], exp_r[k][2]}) begin
                n_bad++;
                $display("FAIL cross_%0d got=(%h,%h,%h) want=(%h,%h,%h)", k, cp_rx, cp_ry, cp_rz,
                         exp_r[k][0], exp_r[k][1], exp_r[k][2]);
            end
        end
    endtask

    task automatic test_norm_basic();
        int lat, nv;
        logic bav;
        norm_request(32'h30000, 32'h40000, 32'h0, lat, nv, bav);
        n_total++;
        if (nv !== 1 || lat < 0 || lat > 80) begin
            n_bad++; $display("FAIL norm_handshake valids=%0d latency=%0d want 1 valid within 80", nv, lat);
        end
        n_total++;
        if (bav !== 1'b0) begin
            n_bad++; $display("FAIL norm_busy_at_valid got=%b want=0", bav);
        end
        n_total++;
        if (absdiff(norm_nx, 39321) > c_norm_tol || absdiff(norm_ny, 52428) > c_norm_tol ||
            absdiff(norm_nz, 0) > c_norm_tol) begin
            n_bad++; $display("FAIL norm_vec got=(%0d,%0d,%0d) want=(39321,52428,0)",
                              $signed(norm_nx), $signed(norm_ny), $signed(norm_nz));
        end
        n_total++;
        if (absdiff(norm_inv_mag, 13107) > c_norm_tol) begin
            n_bad++; $display("FAIL norm_inv got=%0d want=13107", norm_inv_mag);
        end
    endtask

    task automatic test_norm_zero();
        int lat, nv;
        logic bav;
        norm_request(32'h0, 32'h0, 32'h0, lat, nv, bav);
        n_total++;
        if (nv !== 1) begin
            n_bad++; $display("FAIL norm_zero_valid got=%0d want=1", nv);
        end
        n_total++;
        if ({norm_nx, norm_ny, norm_nz, norm_inv_mag} !== 128'd0) begin
            n_bad++; $display("FAIL norm_zero_data got nx=%h ny=%h nz=%h inv=%h want 0",
                              norm_nx, norm_ny, norm_nz, norm_inv_mag);
        end
`ifdef NORM_ZERO_FLAG_EN
        n_total++;
        if (norm_zero !== 1'b1) begin
            n_bad++; $display("FAIL norm_zero_flag got=%b want=1", norm_zero);
        end
`endif
    endtask

    task automatic test_acos();
        logic [31:0] xs [5];
        int          want [5];
        int lat, nv;
        xs   = '{32'h0, 32'h10000, 32'hFFFF0000, 32'h8000, 32'h20000};
        want = '{102939, 0, 205887, 68629, 0};
        for (int k = 0; k < 5; k++) begin
            acos_request(xs[k], lat, nv);
            n_total++;
            if (nv !== 1 || lat < 0 || lat > 40 || absdiff(acos_theta, want[k]) > c_acos_tol) begin
                n_bad++;
                $display("FAIL acos_%0d x=%h got theta=%0d valids=%0d lat=%0d want theta=%0d",
                         k, xs[k], $signed(acos_theta), nv, lat, want[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard, nv, lat;
        @(negedge clk);
        acos_x = 32'hFFFF0000; acos_start = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!acos_busy && guard < 10);
        acos_start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({acos_busy, acos_valid} !== 2'b00 || acos_theta !== 32'd0 || norm_inv_mag !== 32'd0) begin
            n_bad++; $display("FAIL reset_mid_clear busy=%b valid=%b theta=%h inv=%h want 0",
                              acos_busy, acos_valid, acos_theta, norm_inv_mag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (acos_valid) nv++;
        end
        n_total++;
        if (nv !== 0) begin
            n_bad++; $display("FAIL reset_mid_no_valid got=%0d valids want=0", nv);
        end
        acos_request(32'h0, lat, nv);
        n_total++;
        if (nv !== 1 || absdiff(acos_theta, 102939) > c_acos_tol) begin
            n_bad++; $display("FAIL reset_mid_recover got theta=%0d valids=%0d want 102939",
                              $signed(acos_theta), nv);
        end
    endtask

    task automatic test_back_to_back();
        int guard, nv;
        @(negedge clk);
        norm_vx = 32'h30000; norm_vy = 32'h40000; norm_vz = 32'h0; norm_start = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!norm_busy && guard < 10);
        norm_start = 1'b0;
        repeat (5) @(negedge clk);
        norm_vx = 32'h10000; norm_vy = 32'h0; norm_vz = 32'h0; norm_start = 1'b1;
        @(negedge clk);
        norm_start = 1'b0;
        nv = 0;
        for (int i = 0; i < 120; i++) begin
            if (norm_valid) nv++;
            @(negedge clk);
        end
        n_total++;
        if (nv !== 1) begin
            n_bad++; $display("FAIL b2b_valids got=%0d want=1", nv);
        end
        n_total++;
        if (absdiff(norm_nx, 39321) > c_norm_tol || absdiff(norm_ny, 52428) > c_norm_tol ||
            absdiff(norm_inv_mag, 13107) > c_norm_tol) begin
            n_bad++; $display("FAIL b2b_result got nx=%0d ny=%0d inv=%0d want 39321/52428/13107",
                              $signed(norm_nx), $signed(norm_ny), norm_inv_mag);
        end
    endtask

    initial begin
        test_reset();
        test_cross();
        test_norm_basic();
        test_norm_zero();
        test_acos();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
